// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and default constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states: normal flow, waiting on a multi-cycle SRAM access,
    // and the trapped state after the SRAM watchdog fires.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_TMR_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_r;
    logic         at_max_s;

    assign at_max_s = (cnt_r == {W{1'b1}});

    // Count one per asserted inc, pinning at the maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (inc && !at_max_s) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign q = cnt_r;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use hazards, multi-cycle SRAM
// accesses and taken branches into per-stage freeze/flush controls, keeps
// saturating stall statistics and traps a hung SRAM access.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMR_W   = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_err,
    output logic [CNT_W-1:0] hazard_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic             mem_err_r;
    logic             set_err_s;

    logic             freeze_all_s;
    logic             bubble_s;
    logic             flush_s;
    logic             inc_hazard_s;
    logic             inc_wait_s;
    logic             inc_flush_s;

    // Next-state, timer and freeze/flush decode; all controls drop while rst is high.
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        set_err_s    = 1'b0;
        freeze_all_s = 1'b0;
        bubble_s     = 1'b0;
        flush_s      = 1'b0;
        inc_wait_s   = 1'b0;
        if (rst) begin
            state_nxt_s = RUN;
            timer_nxt_s = {TMR_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        freeze_all_s = 1'b1;
                        inc_wait_s   = 1'b1;
                        state_nxt_s  = MEM_WAIT;
                        timer_nxt_s  = {{(TMR_W-1){1'b0}}, 1'b1};
                    end else if (branch_taken) begin
                        flush_s = 1'b1;
                    end else if (hazard) begin
                        bubble_s = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        // Completion always wins, even on the timeout cycle.
                        state_nxt_s = RUN;
                        timer_nxt_s = {TMR_W{1'b0}};
                        if (branch_taken) begin
                            flush_s = 1'b1;
                        end else if (hazard) begin
                            bubble_s = 1'b1;
                        end else begin
                            flush_s = 1'b0;
                        end
                    end else begin
                        freeze_all_s = 1'b1;
                        inc_wait_s   = 1'b1;
                        if (timer_r == TMR_W'(TIMEOUT)) begin
                            state_nxt_s = ERR;
                            set_err_s   = 1'b1;
                        end else begin
                            timer_nxt_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ERR: begin
                    freeze_all_s = 1'b1;
                end
                default: begin
                    // Unreachable encoding: freeze and recover to RUN.
                    freeze_all_s = 1'b1;
                    state_nxt_s  = RUN;
                    timer_nxt_s  = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    assign inc_hazard_s = bubble_s;
    assign inc_flush_s  = flush_s;

    assign freeze_if    = freeze_all_s | bubble_s;
    assign freeze_id    = freeze_all_s;
    assign freeze_exe   = freeze_all_s;
    assign freeze_mem   = freeze_all_s;
    assign flush_if_id  = flush_s;
    assign flush_id_exe = flush_s | bubble_s;
    assign mem_err      = mem_err_r;

    // State, wait timer and sticky watchdog error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= RUN;
            timer_r   <= {TMR_W{1'b0}};
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            mem_err_r <= mem_err_r | set_err_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_hazard_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_hazard_s),
        .q   (hazard_cnt)
    );

    sat_counter #(.W(CNT_W)) u_memwait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_wait_s),
        .q   (memwait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (inc_flush_s),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus
// randomized traffic, all compared against a behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int TMR_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             hazard;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             freeze_if;
    logic             freeze_id;
    logic             freeze_exe;
    logic             freeze_mem;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic             mem_err;
    logic [CNT_W-1:0] hazard_cnt;
    logic [CNT_W-1:0] memwait_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks;
    int errors;

    // Model: is an SRAM access stalled, how many stalled cycles so far
    // (request cycle included), trapped flag, and event totals.
    bit m_busy;
    int m_stalls;
    bit m_err;
    int m_haz;
    int m_wait;
    int m_flush;

    pipeline_stall_ctrl #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .freeze_if    (freeze_if),
        .freeze_id    (freeze_id),
        .freeze_exe   (freeze_exe),
        .freeze_mem   (freeze_mem),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .mem_err      (mem_err),
        .hazard_cnt   (hazard_cnt),
        .memwait_cnt  (memwait_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // One clock cycle: drive inputs after the edge, compare against the model,
    // then advance the model to what the next edge should produce.
    task automatic step(input bit r, input bit mq, input bit rdy, input bit br, input bit hz);
        bit stall_all;
        bit free_flow;
        bit do_flush;
        bit do_bubble;
        bit wait_cycle;
        @(posedge clk);
        #1;
        rst          = r;
        mem_req      = mq;
        mem_ready    = rdy;
        branch_taken = br;
        hazard       = hz;
        #1;
        stall_all  = !r && (m_err || (!rdy && (m_busy || mq)));
        free_flow  = !r && !m_err && !stall_all;
        do_flush   = free_flow && br;
        do_bubble  = free_flow && !br && hz;
        wait_cycle = !r && !m_err && !rdy && (m_busy || mq);

        check_val("freeze_if",    freeze_if,    stall_all || do_bubble);
        check_val("freeze_id",    freeze_id,    stall_all);
        check_val("freeze_exe",   freeze_exe,   stall_all);
        check_val("freeze_mem",   freeze_mem,   stall_all);
        check_val("flush_if_id",  flush_if_id,  do_flush);
        check_val("flush_id_exe", flush_id_exe, do_flush || do_bubble);
        check_val("mem_err",      mem_err,      m_err);
        check_val("hazard_cnt",   hazard_cnt,   m_haz);
        check_val("memwait_cnt",  memwait_cnt,  m_wait);
        check_val("flush_cnt",    flush_cnt,    m_flush);

        if (r) begin
            m_busy = 1'b0; m_stalls = 0; m_err = 1'b0;
            m_haz = 0; m_wait = 0; m_flush = 0;
        end else begin
            if (do_bubble)  m_haz   = sat_inc(m_haz);
            if (do_flush)   m_flush = sat_inc(m_flush);
            if (wait_cycle) m_wait  = sat_inc(m_wait);
            if (m_busy) begin
                if (rdy) begin
                    m_busy = 1'b0;
                end else begin
                    m_stalls++;
                    // The request cycle plus TIMEOUT waiting cycles exhaust the watchdog.
                    if (m_stalls == TIMEOUT + 1) begin
                        m_busy = 1'b0;
                        m_err  = 1'b1;
                    end
                end
            end else if (!m_err && mq && !rdy) begin
                m_busy   = 1'b1;
                m_stalls = 1;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    // Hard time limit so the bench never hangs.
    initial begin
        #2000000;
        $display("FAIL timeout simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit mq_h;
        bit rdy_r;
        checks = 0; errors = 0;
        m_busy = 1'b0; m_stalls = 0; m_err = 1'b0;
        m_haz = 0; m_wait = 0; m_flush = 0;
        rst = 1'b1; mem_req = 1'b0; mem_ready = 1'b0;
        branch_taken = 1'b0; hazard = 1'b0;

        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset_hazard_cnt", hazard_cnt, 0);
        check_val("reset_mem_err", mem_err, 0);

        // Single hazard bubble.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("hazard_one", hazard_cnt, 1);

        // Branch overrides a simultaneous hazard.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("branch_flush_cnt", flush_cnt, 1);
        check_val("branch_hazard_cnt", hazard_cnt, 0);

        // SRAM access with mem_ready four cycles after the request.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("sram_wait_cnt", memwait_cnt, 4);
        check_val("sram_back_run", freeze_mem, 0);

        // Zero-wait access.
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("zero_wait_cnt", memwait_cnt, 0);

        // Watchdog fires: request cycle plus TIMEOUT cycles without ready.
        do_reset();
        for (int i = 0; i < TIMEOUT + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("wdog_err", mem_err, 1);
        check_val("wdog_freeze", freeze_if, 1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("err_sticky", mem_err, 1);
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("wdog_cleared", mem_err, 0);

        // Ready in the last waiting cycle: completion wins.
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("late_ready_no_err", mem_err, 0);
        check_val("late_ready_wait_cnt", memwait_cnt, TIMEOUT);

        // Saturation of the hazard counter.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("hazard_sat", hazard_cnt, CNT_MAX);

        // Reset in the middle of a stalled access.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_val("rst_mid_freeze", freeze_mem, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("rst_mid_wait_cnt", memwait_cnt, 0);
        check_val("rst_mid_hazard_cnt", hazard_cnt, 0);

        // Randomized traffic; mem_req stays up while an access is stalled.
        mq_h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_busy) mq_h = 1'b1;
            else        mq_h = ($urandom_range(0, 99) < 25);
            rdy_r = ($urandom_range(0, 99) < (m_busy ? 20 : 50));
            step(($urandom_range(0, 999) < 8),
                 mq_h, rdy_r,
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 25));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
